nn_layer_engine: RTL

Parametrised fully-connected layer engine for the neural network core. On `start` it computes M neurons, each a signed fixed-point dot product of an N-element input vector with a per-neuron weight row plus bias. Each result is rounded, optionally ReLU-clamped and saturated. Inputs, weights and biases are read from external synchronous ROMs through address ports. One result is emitted per neuron through a `out_valid` strobe, and `ready` marks the idle state.

---
 rtl/nn_layer_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/nn_layer_engine.sv
// Fully-connected layer engine: per neuron, bias plus an N-term signed MAC over
// ROM-fed inputs and weights, then round, optional ReLU, saturate, and one strobe.
module nn_layer_engine #(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int W    = 16,
    parameter int FRAC = 8,
    localparam int XA  = (N > 1) ? $clog2(N) : 1,
    localparam int WA  = (N * M > 1) ? $clog2(N * M) : 1,
    localparam int BA  = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          relu_en,
    output logic [XA-1:0] x_addr,
    input  logic [W-1:0]  x_data,
    output logic [WA-1:0] w_addr,
    input  logic [W-1:0]  w_data,
    output logic [BA-1:0] b_addr,
    input  logic [W-1:0]  b_data,
    output logic [W-1:0]  out,
    output logic [BA-1:0] out_idx,
    output logic          out_valid,
    output logic          done,
    output logic          ready
);
    localparam int ACCW = 2 * W + $clog2(N) + 1;
    localparam logic signed [ACCW-1:0] HALF = ACCW'((64'd1 << FRAC) >> 1);
    localparam logic signed [ACCW-1:0] MAXV = ACCW'({1'b0, {(W-1){1'b1}}});
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {S_IDLE, S_BIAS, S_MAC, S_OUT} state_t;

    state_t                 state, state_nx;
    logic [BA-1:0]          j;
    logic [XA-1:0]          k;
    logic                   relu_q;
    logic                   accept;
    logic                   k_last, j_last;
    logic [WA-1:0]          row_base;
    logic signed [ACCW-1:0] acc;

    logic signed [W-1:0]    xs, ws, bs;
    logic signed [2*W-1:0]  prod;
    logic signed [ACCW-1:0] prod_e, bias_e, rnd, clip;

    assign k_last   = (k == XA'(N - 1));
    assign j_last   = (j == BA'(M - 1));
    assign row_base = WA'(32'(j) * 32'(N));

    assign ready = (state == S_IDLE);
    assign done  = out_valid && (out_idx == BA'(M - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // With start held, the last OUT chains straight into the next run's BIAS.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_nx = S_BIAS;
                accept   = 1'b1;
            end
            S_BIAS: state_nx = S_MAC;
            S_MAC:  if (k_last) state_nx = S_OUT;
            S_OUT: begin
                if (!j_last) begin
                    state_nx = S_BIAS;
                end else if (start) begin
                    state_nx = S_BIAS;
                    accept   = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ROM addresses lead the data by one cycle: BIAS fetches element 0 and the
    // bias, each MAC cycle fetches the element consumed in the following one.
    always_comb begin
        x_addr = '0;
        w_addr = '0;
        b_addr = '0;
        case (state)
            S_BIAS: begin
                w_addr = row_base;
                b_addr = j;
            end
            S_MAC: if (!k_last) begin
                x_addr = k + XA'(1);
                w_addr = row_base + WA'(k) + WA'(1);
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    assign xs     = x_data;
    assign ws     = w_data;
    assign bs     = b_data;
    assign prod   = xs * ws;
    assign prod_e = ACCW'(prod);
    assign bias_e = ACCW'(bs) <<< FRAC;

    always_comb begin
        rnd  = (acc + HALF) >>> FRAC;
        clip = rnd;
        if (relu_q && rnd[ACCW-1]) clip = '0;
        if (clip > MAXV)      clip = MAXV;
        else if (clip < MINV) clip = MINV;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            relu_q    <= 1'b0;
            out       <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) relu_q <= relu_en;
            case (state)
                S_BIAS: k <= '0;
                S_MAC: begin
                    acc <= ((k == '0) ? bias_e : acc) + prod_e;
                    k   <= k + XA'(1);
                end
                S_OUT: begin
                    out       <= clip[W-1:0];
                    out_idx   <= j;
                    out_valid <= 1'b1;
                    j         <= j_last ? '0 : j + BA'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
